class_search: RTL and testbench



---
 rtl/class_search.sv | 90 +++++++++
 tb/tb_class_search.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/class_search.sv
// rtl/class_search.sv - streaming arg-min over (distance, class) beats
// Holds the smallest distance of a frame and presents the winning class when the frame closes.
module class_search #(
  parameter int DW   = 32,
  parameter int CLSW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inValid,
  output logic            inReady,
  input  logic [DW-1:0]   inDist,
  input  logic [CLSW-1:0] inNum,
  input  logic            inLast,
  output logic            outValid,
  input  logic            outReady,
  output logic [DW-1:0]   outDist,
  output logic [CLSW-1:0] outNum,
  output logic [CLSW-1:0] outCount
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t          state;
  logic [DW-1:0]   best_dist;
  logic [CLSW-1:0] best_num;
  logic [CLSW-1:0] count;

  // Best/count registers stay frozen through HOLD, so they drive the result directly.
  assign outDist  = best_dist;
  assign outNum   = best_num;
  assign outCount = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      inReady   <= 1'b1;
      outValid  <= 1'b0;
      best_dist <= '0;
      best_num  <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            best_dist <= inDist;
            best_num  <= inNum;
            count     <= CLSW'(1);
            if (inLast) begin
              state    <= HOLD;
              inReady  <= 1'b0;
              outValid <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (inValid) begin
            // Strict compare: on ties the earliest beat keeps the win.
            if (inDist < best_dist) begin
              best_dist <= inDist;
              best_num  <= inNum;
            end
            if (count != '1) begin
              count <= count + CLSW'(1);
            end
            if (inLast) begin
              state    <= HOLD;
              inReady  <= 1'b0;
              outValid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (outReady) begin
            state    <= IDLE;
            inReady  <= 1'b1;
            outValid <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          inReady  <= 1'b1;
          outValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_class_search.sv
// tb/tb_class_search.sv - directed bench for class_search
// Main instance uses default widths; a CLSW=4 instance exercises count saturation.
module tb_class_search;

  logic        clk;
  logic        rst_n;
  logic        inValid, inReady, inLast, outValid, outReady;
  logic [31:0] inDist, outDist;
  logic [15:0] inNum, outNum, outCount;

  logic        s_inValid, s_inReady, s_inLast, s_outValid, s_outReady;
  logic [31:0] s_inDist, s_outDist;
  logic [3:0]  s_inNum, s_outNum, s_outCount;

  int checks;
  int failures;

  class_search #(.DW(32), .CLSW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .inValid(inValid), .inReady(inReady), .inDist(inDist), .inNum(inNum), .inLast(inLast),
    .outValid(outValid), .outReady(outReady), .outDist(outDist), .outNum(outNum),
    .outCount(outCount)
  );

  class_search #(.DW(32), .CLSW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .inValid(s_inValid), .inReady(s_inReady), .inDist(s_inDist), .inNum(s_inNum),
    .inLast(s_inLast), .outValid(s_outValid), .outReady(s_outReady), .outDist(s_outDist),
    .outNum(s_outNum), .outCount(s_outCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [15:0] n, input logic last);
    inValid = 1'b1;
    inDist  = d;
    inNum   = n;
    inLast  = last;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic accept_result();
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    inValid = 1'b0; inDist = '0; inNum = '0; inLast = 1'b0; outReady = 1'b0;
    s_inValid = 1'b0; s_inDist = '0; s_inNum = '0; s_inLast = 1'b0; s_outReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inReady", inReady, 1);
    check("rst_outValid", outValid, 0);
    check("rst_outDist", outDist, 0);
    check("rst_outNum", outNum, 0);
    check("rst_outCount", outCount, 0);
    check("rst_sat_outValid", s_outValid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic four-beat frame
    send(9, 0, 0);
    send(5, 1, 0);
    send(7, 2, 0);
    check("f1_not_yet_valid", outValid, 0);
    send(3, 3, 1);
    check("f1_outValid", outValid, 1);
    check("f1_outDist", outDist, 3);
    check("f1_outNum", outNum, 3);
    check("f1_outCount", outCount, 4);
    check("f1_inReady_hold", inReady, 0);
    accept_result();
    check("f1_outValid_drop", outValid, 0);
    check("f1_inReady_back", inReady, 1);

    // Ties keep the earlier class
    send(6, 10, 0);
    send(2, 11, 0);
    send(2, 12, 0);
    send(4, 13, 1);
    check("tie_outDist", outDist, 2);
    check("tie_outNum", outNum, 11);
    check("tie_outCount", outCount, 4);
    accept_result();

    // Single-beat frame at max distance, then back-pressure with an offered beat
    send(32'hFFFF_FFFF, 7, 1);
    check("single_outValid", outValid, 1);
    check("single_outDist", outDist, 32'hFFFF_FFFF);
    check("single_outNum", outNum, 7);
    check("single_outCount", outCount, 1);
    inValid = 1'b1; inDist = 0; inNum = 99; inLast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_outValid", outValid, 1);
      check("bp_inReady", inReady, 0);
      check("bp_outDist", outDist, 32'hFFFF_FFFF);
      check("bp_outNum", outNum, 7);
      check("bp_outCount", outCount, 1);
    end
    inValid = 1'b0; inLast = 1'b0;
    accept_result();
    check("bp_release_outValid", outValid, 0);
    check("bp_release_inReady", inReady, 1);

    // Gaps in ACC: invalid cycles carry a tempting distance that must be ignored
    send(8, 20, 0);
    inDist = 0; inNum = 99; inLast = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("gap_no_result", outValid, 0);
    send(4, 22, 1);
    check("gap_outValid", outValid, 1);
    check("gap_outDist", outDist, 4);
    check("gap_outNum", outNum, 22);
    check("gap_outCount", outCount, 2);
    accept_result();

    // Asynchronous reset while holding a result
    send(1, 30, 0);
    send(2, 31, 1);
    check("pre_rst_outValid", outValid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outValid", outValid, 0);
    check("async_rst_inReady", inReady, 1);
    check("async_rst_outCount", outCount, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8, 4, 0);
    send(1, 5, 1);
    check("post_rst_outDist", outDist, 1);
    check("post_rst_outNum", outNum, 5);
    check("post_rst_outCount", outCount, 2);
    accept_result();

    // Saturation on the narrow instance: 20 beats, minimum at beat 17
    for (int i = 1; i <= 20; i++) begin
      s_inValid = 1'b1;
      s_inDist  = (i == 17) ? 32'd1 : 32'(50 + i);
      s_inNum   = (i == 17) ? 4'd2 : 4'(i);
      s_inLast  = (i == 20);
      @(posedge clk);
      #1;
    end
    s_inValid = 1'b0; s_inLast = 1'b0;
    check("sat_outValid", s_outValid, 1);
    check("sat_outCount", s_outCount, 15);
    check("sat_outNum", s_outNum, 2);
    check("sat_outDist", s_outDist, 1);
    s_outReady = 1'b1;
    @(posedge clk);
    #1;
    s_outReady = 1'b0;
    check("sat_release", s_outValid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
